// File: rtl/fifo_rr_scheduler_if.sv
// fifo_rr_scheduler_if: strobes and data between the VC ingress FIFOs, the scheduler and the egress FIFO.
interface fifo_rr_scheduler_if #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_IN    = 4
);
    logic                        enable;
    logic [NUM_IN-1:0]           in_empty;
    logic [NUM_IN-1:0]           in_error;
    logic [NUM_IN*DATA_SIZE-1:0] in_data;
    logic                        out_almost_full;
    logic                        out_error;
    logic [NUM_IN-1:0]           read;
    logic                        out_write;
    logic [DATA_SIZE-1:0]        out_data;
    logic [1:0]                  out_src;
    logic [NUM_IN-1:0]           grant;
    logic [1:0]                  state;
    logic                        err_sticky;

    modport master (
        input  enable, in_empty, in_error, in_data, out_almost_full, out_error,
        output read, out_write, out_data, out_src, grant, state, err_sticky
    );

    modport slave (
        output enable, in_empty, in_error, in_data, out_almost_full, out_error,
        input  read, out_write, out_data, out_src, grant, state, err_sticky
    );
endinterface

// File: rtl/fifo_rr_scheduler.sv
// fifo_rr_scheduler: round-robin burst drain of four VC input FIFOs into one egress FIFO,
// with a 2-cycle pop-to-push pipeline and almost_full back-pressure.
module fifo_rr_scheduler #(
    parameter int DATA_SIZE = 8,
    parameter int NUM_IN    = 4,
    parameter int BURST_LEN = 3
) (
    input  logic                clk,
    input  logic                reset,
    fifo_rr_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE = 2'b00, BURST = 2'b01, PAUSE = 2'b10} state_t;

    state_t               st;
    logic [1:0]           ptr, cur, first, src1, out_src_q;
    logic [2:0]           cnt;
    logic                 go, pop, last, v1, out_write_q, err_q;
    logic [DATA_SIZE-1:0] out_data_q;

    assign go   = bus.enable && !bus.out_almost_full;
    assign pop  = st == BURST && go && !bus.in_empty[cur];
    assign last = pop && cnt == 3'(BURST_LEN - 1);

    // descending scan so the nearest non-empty FIFO at or after ptr wins
    always_comb begin
        first = ptr;
        for (int k = NUM_IN - 1; k >= 0; k--)
            if (!bus.in_empty[ptr + 2'(k)]) first = ptr + 2'(k);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st  <= IDLE;
            ptr <= '0;
            cur <= '0;
            cnt <= '0;
        end else begin
            case (st)
                IDLE:
                    if (go && |(~bus.in_empty)) begin
                        st  <= BURST;
                        cur <= first;
                        cnt <= '0;
                    end
                BURST:
                    if (last || (!pop && bus.in_empty[cur])) begin
                        st  <= IDLE;
                        ptr <= cur + 2'd1;
                        cnt <= '0;
                    end else if (pop) cnt <= cnt + 3'd1;
                    else st <= PAUSE;
                PAUSE:   if (go) st <= BURST;
                default: st <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1          <= 1'b0;
            src1        <= '0;
            out_write_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            v1          <= pop;
            src1        <= pop ? cur : src1;
            out_write_q <= v1;
            out_data_q  <= v1 ? bus.in_data[src1*DATA_SIZE +: DATA_SIZE] : out_data_q;
            out_src_q   <= v1 ? src1 : out_src_q;
            err_q       <= err_q | (|bus.in_error) | bus.out_error;
        end
    end

    assign bus.read       = pop ? NUM_IN'(1) << cur : '0;
    assign bus.grant      = st == IDLE ? '0 : NUM_IN'(1) << cur;
    assign bus.state      = st;
    assign bus.out_write  = out_write_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;
    assign bus.err_sticky = err_q;
endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// tb_fifo_rr_scheduler: queue-modelled input FIFOs plus a round-robin reference model of the
// expected egress word order, with directed timing scenarios and randomized back-pressure.
module tb_fifo_rr_scheduler;
    localparam int BL = 3;

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] data;
    } word_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    fifo_rr_scheduler_if bus ();

    fifo_rr_scheduler #(.DATA_SIZE(8), .NUM_IN(4), .BURST_LEN(BL)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         passed = 0, total = 0;
    logic [7:0] q [4][$];
    logic [7:0] dreg [4];
    word_t      egress [$], expect_q [$];
    logic [1:0] exp_bursts [$];
    logic [3:0] got_grants [$];
    logic [3:0] rd_log [$];
    logic [1:0] st_log [$];
    logic       ow_log [$];
    logic [3:0] prev_r;
    logic [1:0] last_st;

    logic [3:0] t2_rd [8]  = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4, 4'h0};
    logic [1:0] t2_st [8]  = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1};
    logic [3:0] t4_rd [10] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
    logic [1:0] t4_st [10] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};
    logic       t4_ow [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] t5_rd [9]  = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [1:0] t5_st [9]  = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [1:0] enc(input logic [3:0] oh);
        return oh[3] ? 2'd3 : oh[2] ? 2'd2 : oh[1] ? 2'd1 : 2'd0;
    endfunction

    function automatic bit all_empty();
        return q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0;
    endfunction

    task automatic sync_in();
        for (int i = 0; i < 4; i++) begin
            bus.in_empty[i]       = q[i].size() == 0;
            bus.in_data[i*8 +: 8] = dreg[i];
        end
    endtask

    // one clock: sample strobes mid-cycle, then apply pops and capture pushes just after the edge
    task automatic tick();
        logic [3:0] r;
        sync_in();
        #2;
        r = bus.read;
        rd_log.push_back(r);
        st_log.push_back(bus.state);
        if (bus.state == 2'd1 && last_st == 2'd0) got_grants.push_back(bus.grant);
        last_st = bus.state;
        chk("read_onehot", 32'($onehot0(r)), 1);
        chk("read_of_empty", r & bus.in_empty, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (r[i]) dreg[i] = q[i].pop_front();
        sync_in();
        chk("push_latency", bus.out_write, |prev_r);
        if (prev_r != 4'h0) chk("push_src", bus.out_src, enc(prev_r));
        if (bus.out_write) egress.push_back({bus.out_src, bus.out_data});
        ow_log.push_back(bus.out_write);
        prev_r = r;
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_state"}, bus.state, 0);
        chk({tag, "_read"}, bus.read, 0);
        chk({tag, "_grant"}, bus.grant, 0);
        chk({tag, "_out_write"}, bus.out_write, 0);
        chk({tag, "_out_data"}, bus.out_data, 0);
        chk({tag, "_out_src"}, bus.out_src, 0);
        chk({tag, "_err_sticky"}, bus.err_sticky, 0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.enable = 1'b0;
        bus.out_almost_full = 1'b0;
        bus.in_error = '0;
        bus.out_error = 1'b0;
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            dreg[i] = '0;
        end
        egress.delete();
        expect_q.delete();
        exp_bursts.delete();
        got_grants.delete();
        rd_log.delete();
        st_log.delete();
        ow_log.delete();
        prev_r = '0;
        last_st = '0;
        sync_in();
        @(posedge clk);
        #1;
        rst_checks("reset");
        reset = 1'b1;
    endtask

    task automatic preload(input int n0, input int n1, input int n2, input int n3);
        int n [4];
        n = '{n0, n1, n2, n3};
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < n[i]; j++) q[i].push_back(8'($urandom));
    endtask

    // reference: take up to BL words from the first non-empty FIFO at/after ptr, then ptr = src+1
    task automatic build_model();
        logic [7:0] m [4][$];
        int p, n, s;
        for (int i = 0; i < 4; i++) m[i] = q[i];
        expect_q.delete();
        exp_bursts.delete();
        p = 0;
        while (m[0].size() + m[1].size() + m[2].size() + m[3].size() > 0) begin
            s = -1;
            for (int k = 0; k < 4; k++)
                if (s < 0 && m[(p + k) % 4].size() > 0) s = (p + k) % 4;
            exp_bursts.push_back(2'(s));
            n = m[s].size() < BL ? m[s].size() : BL;
            for (int j = 0; j < n; j++) expect_q.push_back({2'(s), m[s].pop_front()});
            p = (s + 1) % 4;
        end
    endtask

    task automatic drain(input int budget, input bit rnd);
        int c = 0;
        while (c < budget && !(all_empty() && bus.state == 2'd0 && prev_r == 4'h0 && !bus.out_write)) begin
            if (rnd) begin
                bus.enable = $urandom_range(0, 3) != 0;
                bus.out_almost_full = $urandom_range(0, 3) == 0;
            end
            tick();
            c++;
        end
        chk("drain_within_budget", 32'(c < budget), 1);
        bus.enable = 1'b1;
        bus.out_almost_full = 1'b0;
    endtask

    task automatic check_egress(input string tag);
        chk({tag, "_word_count"}, egress.size(), expect_q.size());
        for (int i = 0; i < expect_q.size() && i < egress.size(); i++)
            chk({tag, "_word"}, egress[i], expect_q[i]);
        chk({tag, "_burst_count"}, got_grants.size(), exp_bursts.size());
        for (int i = 0; i < exp_bursts.size() && i < got_grants.size(); i++)
            chk({tag, "_grant"}, got_grants[i], 4'h1 << exp_bursts[i]);
    endtask

    initial begin
        int first_b, last_b, idles, pauses;

        // asynchronous reset in the middle of a burst
        do_reset();
        preload(6, 0, 0, 0);
        bus.enable = 1'b1;
        repeat (3) tick();
        chk("t1_in_burst", bus.state, 1);
        reset = 1'b0;
        #1;
        rst_checks("t1_async");
        do_reset();
        bus.enable = 1'b1;
        repeat (4) begin
            tick();
            chk("t1_no_write_after_reset", bus.out_write, 0);
        end

        // single FIFO, five words, bursts of three then two
        do_reset();
        for (int j = 0; j < 5; j++) q[2].push_back(8'hA0 + 8'(j));
        build_model();
        bus.enable = 1'b1;
        repeat (8) tick();
        for (int i = 0; i < 8; i++) begin
            chk("t2_read", rd_log[i], t2_rd[i]);
            chk("t2_state", st_log[i], t2_st[i]);
        end
        chk("t2_no_push_1_after_read", ow_log[1], 0);
        chk("t2_push_2_after_read", ow_log[2], 1);
        drain(100, 1'b0);
        check_egress("t2");

        // all four full: grants rotate 0,1,2,3,0,... with one bubble between bursts
        do_reset();
        preload(6, 6, 6, 6);
        build_model();
        bus.enable = 1'b1;
        drain(200, 1'b0);
        check_egress("t3");
        first_b = -1;
        last_b = -1;
        for (int i = 0; i < st_log.size(); i++)
            if (st_log[i] == 2'd1) begin
                if (first_b < 0) first_b = i;
                last_b = i;
            end
        idles = 0;
        pauses = 0;
        for (int i = first_b; i >= 0 && i <= last_b; i++) begin
            if (st_log[i] == 2'd0) idles++;
            if (st_log[i] == 2'd2) pauses++;
        end
        chk("t3_bubbles", idles, exp_bursts.size() - 1);
        chk("t3_no_pause", pauses, 0);

        // almost_full for four cycles after two pops: pause, then exactly one more pop
        do_reset();
        preload(6, 0, 0, 0);
        build_model();
        bus.enable = 1'b1;
        repeat (3) tick();
        bus.out_almost_full = 1'b1;
        repeat (4) tick();
        bus.out_almost_full = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 10; i++) begin
            chk("t4_read", rd_log[i], t4_rd[i]);
            chk("t4_state", st_log[i], t4_st[i]);
            chk("t4_out_write", ow_log[i], t4_ow[i]);
        end
        drain(100, 1'b0);
        check_egress("t4");

        // FIFO1 runs dry after one pop: burst ends, ptr moves to 2, enable=0 stops pops
        do_reset();
        q[1].push_back(8'h51);
        q[3].push_back(8'h31);
        q[3].push_back(8'h32);
        bus.enable = 1'b1;
        repeat (3) tick();
        q[1].push_back(8'h52);
        repeat (2) tick();
        bus.enable = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 9; i++) begin
            chk("t5_read", rd_log[i], t5_rd[i]);
            chk("t5_state", st_log[i], t5_st[i]);
        end
        bus.enable = 1'b1;
        drain(100, 1'b0);
        expect_q = '{'{2'd1, 8'h51}, '{2'd3, 8'h31}, '{2'd3, 8'h32}, '{2'd1, 8'h52}};
        exp_bursts = '{2'd1, 2'd3, 2'd1};
        check_egress("t5");

        // one-cycle in_error[3] pulse sets err_sticky without disturbing traffic
        do_reset();
        preload(6, 2, 5, 4);
        build_model();
        bus.enable = 1'b1;
        repeat (5) tick();
        chk("t6_err_before", bus.err_sticky, 0);
        bus.in_error = 4'b1000;
        tick();
        bus.in_error = '0;
        chk("t6_err_set", bus.err_sticky, 1);
        drain(2000, 1'b1);
        chk("t6_err_held", bus.err_sticky, 1);
        check_egress("t6");
        bus.out_error = 1'b1;
        tick();
        bus.out_error = 1'b0;
        chk("t6_out_err_held", bus.err_sticky, 1);

        // randomized fill levels with random enable / almost_full
        for (int it = 0; it < 10; it++) begin
            do_reset();
            preload($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
            build_model();
            drain(2000, 1'b1);
            check_egress("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
